// File: rtl/pipelined_decode_queue.sv
// Decoded-instruction queue: RV32I words are decoded on entry and stored as fields in a DEPTH-entry FIFO.
// Optional illegal-instruction flagging is enabled by defining JZJCOREF_DECODE_ILLEGAL_CHECK_EN.
module pipelined_decode_queue #(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instruction,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [2:0]          out_format,
    output logic [31:0]         out_immediate,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    function automatic logic [2:0] decode_format(input logic [6:0] op);
        logic [2:0] fmt;
        case (op)
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111:             fmt = FMT_J;
            7'b1100011:             fmt = FMT_B;
            7'b0100011:             fmt = FMT_S;
            7'b0110011:             fmt = FMT_R;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: fmt = FMT_I;
            default:                fmt = FMT_R;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] decode_imm(input logic [31:0] ins, input logic [2:0] fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'h000};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    // Any opcode outside the supported set, including ones lacking the 2'b11 suffix, is illegal.
    function automatic logic decode_illegal(input logic [31:0] ins);
        logic ill;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0100011,
            7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111,
            7'b1110011: ill = 1'b0;
            default:    ill = 1'b1;
        endcase
        return ill | (ins[1:0] != 2'b11);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             alive_r;
    logic             push_s;
    logic             pop_s;
    logic [2:0]       dec_format_s;
    logic [31:0]      dec_imm_s;

    logic [6:0]          opcode_mem_r [DEPTH];
    logic [2:0]          funct3_mem_r [DEPTH];
    logic [6:0]          funct7_mem_r [DEPTH];
    logic [4:0]          rs1_mem_r    [DEPTH];
    logic [4:0]          rs2_mem_r    [DEPTH];
    logic [4:0]          rd_mem_r     [DEPTH];
    logic [2:0]          format_mem_r [DEPTH];
    logic [31:0]         imm_mem_r    [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_r     [DEPTH];

    // alive_r holds in_ready low until the first edge after reset is released.
    assign in_ready  = alive_r && (count_r < CNT_W'(DEPTH));
    assign out_valid = (count_r != CNT_W'(0));
    assign push_s    = in_valid && in_ready && !flush;
    assign pop_s     = out_valid && out_ready && !flush;

    // Decode the incoming word ahead of storage.
    always_comb begin
        dec_format_s = FMT_R;
        dec_imm_s    = 32'h0000_0000;
        dec_format_s = decode_format(in_instruction[6:0]);
        dec_imm_s    = decode_imm(in_instruction, dec_format_s);
    end

    // Queue control: pointers, occupancy and the post-reset enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            alive_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            alive_r  <= 1'b1;
        end else begin
            alive_r <= 1'b1;
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clock) begin
        if (push_s) begin
            opcode_mem_r[wr_ptr_r] <= in_instruction[6:0];
            funct3_mem_r[wr_ptr_r] <= in_instruction[14:12];
            funct7_mem_r[wr_ptr_r] <= in_instruction[31:25];
            rs1_mem_r[wr_ptr_r]    <= in_instruction[19:15];
            rs2_mem_r[wr_ptr_r]    <= in_instruction[24:20];
            rd_mem_r[wr_ptr_r]     <= in_instruction[11:7];
            format_mem_r[wr_ptr_r] <= dec_format_s;
            imm_mem_r[wr_ptr_r]    <= dec_imm_s;
            pc_mem_r[wr_ptr_r]     <= in_pc;
        end
    end

    assign out_opcode    = opcode_mem_r[rd_ptr_r];
    assign out_funct3    = funct3_mem_r[rd_ptr_r];
    assign out_funct7    = funct7_mem_r[rd_ptr_r];
    assign out_rs1       = rs1_mem_r[rd_ptr_r];
    assign out_rs2       = rs2_mem_r[rd_ptr_r];
    assign out_rd        = rd_mem_r[rd_ptr_r];
    assign out_format    = format_mem_r[rd_ptr_r];
    assign out_immediate = imm_mem_r[rd_ptr_r];
    assign out_pc        = pc_mem_r[rd_ptr_r];

`ifdef JZJCOREF_DECODE_ILLEGAL_CHECK_EN
    logic illegal_mem_r [DEPTH];

    // Illegal flag travels with its entry.
    always_ff @(posedge clock) begin
        if (push_s) begin
            illegal_mem_r[wr_ptr_r] <= decode_illegal(in_instruction);
        end
    end

    assign out_illegal = illegal_mem_r[rd_ptr_r];
`else
    assign out_illegal = 1'b0;
`endif

endmodule
